softmax_exp_ctrl: RTL and testbench

Sequencing controller for the softmax front end. It reads a vector of number_of_data signed fixed-point scores from a synchronous input buffer and finds the maximum. It then streams (x - max) into the downscale exp block, collects the exp results into an output buffer, and accumulates their sum for the downstream divider. It sits between the score buffer, the exp datapath and the normalisation stage.

---
 rtl/softmax_exp_ctrl.sv | 147 ++++++++++++++
 tb/tb_softmax_exp_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/softmax_exp_ctrl.sv
// Softmax front-end sequencer: finds the vector maximum, streams (x - max) into the exp block,
// stores the exp results in order and accumulates their saturating sum.
module softmax_exp_ctrl #(
  parameter int unsigned data_size      = 32,
  parameter int unsigned number_of_data = 10,
  parameter int unsigned addr_size      = 4,
  parameter int unsigned sum_size       = 36
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rd_en_o,
  output logic [addr_size-1:0] rd_addr_o,
  input  logic [data_size-1:0] rd_data_i,
  output logic                 exp_start_o,
  output logic [data_size-1:0] exp_data_o,
  input  logic                 exp_valid_i,
  input  logic [data_size-1:0] exp_data_i,
  output logic                 wr_en_o,
  output logic [addr_size-1:0] wr_addr_o,
  output logic [data_size-1:0] wr_data_o,
  output logic [sum_size-1:0]  sum_o
);

  // One extra bit so the counters can hold N even when N == 2^addr_size.
  localparam int unsigned CntW = addr_size + 1;
  localparam logic [CntW-1:0] NumData = CntW'(number_of_data);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [data_size-1:0] SignedMin = {1'b1, {(data_size-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMax, StExp, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      res_cnt_q, res_cnt_d;
  logic [data_size-1:0] max_q, max_d;
  logic [sum_size-1:0]  sum_q, sum_d;

  logic                 rd_en;
  logic                 cmp_en;
  logic                 issue_en;
  logic                 collect_en;
  logic                 accept;
  logic [data_size:0]   diff;
  logic [data_size-1:0] diff_sat;
  logic [sum_size:0]    sum_add;

  // State register
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StMax;
      StMax:   if (cnt_q == NumData) state_d = StExp;
      StExp:   if (cnt_q == NumData) state_d = StDrain;
      StDrain: if (res_cnt_d == NumData) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and strobe decode
  always_comb begin
    accept     = (state_q == StIdle) && start_i;
    rd_en      = ((state_q == StMax) || (state_q == StExp)) && (cnt_q < NumData);
    // Read data returns one cycle after each read, i.e. whenever the counter is past zero.
    cmp_en     = (state_q == StMax) && (cnt_q != '0);
    issue_en   = (state_q == StExp) && (cnt_q != '0);
    collect_en = ((state_q == StExp) || (state_q == StDrain)) && exp_valid_i &&
                 (res_cnt_q < NumData);

    busy_o      = (state_q == StMax) || (state_q == StExp) || (state_q == StDrain);
    done_o      = (state_q == StDone);
    rd_en_o     = rd_en;
    rd_addr_o   = rd_en ? cnt_q[addr_size-1:0] : '0;
    exp_start_o = issue_en;
    exp_data_o  = issue_en ? diff_sat : '0;
    wr_en_o     = collect_en;
    wr_addr_o   = collect_en ? res_cnt_q[addr_size-1:0] : '0;
    wr_data_o   = collect_en ? exp_data_i : '0;
    sum_o       = sum_q;
  end

  // Subtract at data_size+1 bits; clamp underflow to the signed minimum and anything
  // non-negative to zero, so the exp block never sees a positive argument.
  always_comb begin
    diff = {rd_data_i[data_size-1], rd_data_i} - {max_q[data_size-1], max_q};
    if (diff[data_size]) begin
      diff_sat = (diff[data_size-1] == 1'b0) ? SignedMin : diff[data_size-1:0];
    end else begin
      diff_sat = '0;
    end
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = '0;
    res_cnt_d = res_cnt_q;
    max_d     = max_q;
    sum_d     = sum_q;
    sum_add   = {1'b0, sum_q} + {{(sum_size + 1 - data_size){1'b0}}, exp_data_i};

    if ((state_q == StMax) || (state_q == StExp)) begin
      cnt_d = (cnt_q == NumData) ? '0 : cnt_q + CntOne;
    end

    if (accept) begin
      max_d     = SignedMin;
      res_cnt_d = '0;
      sum_d     = '0;
    end

    if (cmp_en && ($signed(rd_data_i) > $signed(max_q))) begin
      max_d = rd_data_i;
    end

    if (collect_en) begin
      res_cnt_d = res_cnt_q + CntOne;
      sum_d     = sum_add[sum_size] ? '1 : sum_add[sum_size-1:0];
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q     <= '0;
      res_cnt_q <= '0;
      max_q     <= SignedMin;
      sum_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      res_cnt_q <= res_cnt_d;
      max_q     <= max_d;
      sum_q     <= sum_d;
    end
  end

endmodule

// File: tb/tb_softmax_exp_ctrl.sv
// Directed bench for softmax_exp_ctrl with a buffer model and a fixed-latency exp model.
module tb_softmax_exp_ctrl;

  localparam int DS = 32;
  localparam int N  = 10;
  localparam int AW = 4;
  localparam int SW = 36;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, rd_en, exp_start, exp_valid, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DS-1:0] rd_data = '0;
  logic [DS-1:0] exp_data, exp_result, wr_data;
  logic [SW-1:0] sum;

  softmax_exp_ctrl #(
    .data_size(DS), .number_of_data(N), .addr_size(AW), .sum_size(SW)
  ) dut (
    .clock_i(clock), .reset_n_i(reset_n), .start_i(start), .busy_o(busy), .done_o(done),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .exp_start_o(exp_start), .exp_data_o(exp_data),
    .exp_valid_i(exp_valid), .exp_data_i(exp_result),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .sum_o(sum)
  );

  always #5 clock = ~clock;

  // Score buffer: synchronous read, one cycle latency.
  logic [DS-1:0] mem [0:15];
  always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr];

  // Behavioural exp: 2^16 >> -d, zero for very negative arguments.
  function automatic logic [DS-1:0] exp_model(input logic [DS-1:0] d);
    int ds;
    ds = int'(d);
    if (ds > 0 || ds < -16) return '0;
    return 32'h0001_0000 >> (-ds);
  endfunction

  int            lat = 3;
  logic          spur = 1'b0;
  logic [7:0]    vpipe = '0;
  logic [DS-1:0] dpipe [0:7];
  always @(posedge clock) begin
    vpipe    <= {vpipe[6:0], exp_start};
    dpipe[0] <= exp_model(exp_data);
    for (int i = 1; i < 8; i++) dpipe[i] <= dpipe[i-1];
  end
  assign exp_valid  = vpipe[lat-1] | spur;
  assign exp_result = dpipe[lat-1];

  int n_checks = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  logic [DS-1:0] exp_log[$];
  logic [DS-1:0] wr_data_log[$];
  logic [AW-1:0] wr_addr_log[$];
  int            done_cnt, rd_cnt;
  logic [DS-1:0] want_exp [N];
  logic [DS-1:0] want_wr  [N];
  logic [SW-1:0] want_sum;

  task automatic load_ramp();
    for (int i = 0; i < N; i++) begin
      mem[i]      = 32'(i);
      want_exp[i] = 32'(i - 9);
      want_wr[i]  = 32'h0001_0000 >> (9 - i);
    end
    want_sum = 36'd130944;
  endtask

  task automatic load_equal();
    for (int i = 0; i < N; i++) begin
      mem[i]      = 32'hFFFF_FFFB;
      want_exp[i] = '0;
      want_wr[i]  = 32'h0001_0000;
    end
    want_sum = 36'd655360;
  endtask

  task automatic load_sat();
    mem[0] = 32'h7FFF_FFFF; want_exp[0] = 32'h0000_0000; want_wr[0] = 32'd65536;
    mem[1] = 32'h8000_0000; want_exp[1] = 32'h8000_0000; want_wr[1] = 32'd0;
    mem[2] = 32'h7FFF_FFFE; want_exp[2] = 32'hFFFF_FFFF; want_wr[2] = 32'd32768;
    for (int i = 3; i < N; i++) begin
      mem[i] = 32'h7FFF_FFFD; want_exp[i] = 32'hFFFF_FFFE; want_wr[i] = 32'd16384;
    end
    want_sum = 36'd212992;
  endtask

  task automatic run_pass(input int lat_v, input bit spurious, input bit restart);
    lat = lat_v;
    exp_log.delete();
    wr_data_log.delete();
    wr_addr_log.delete();
    done_cnt = 0;
    rd_cnt = 0;
    @(negedge clock);
    start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      start = restart && (c == 5);
      spur  = spurious && (c == 4);
      #1;
      if (c == 0) check_eq("busy_after_start", 64'(busy), 64'(1));
      if (rd_en) rd_cnt++;
      if (exp_start) exp_log.push_back(exp_data);
      if (wr_en) begin
        wr_addr_log.push_back(wr_addr);
        wr_data_log.push_back(wr_data);
      end
      if (done) begin
        done_cnt++;
        check_eq("busy_in_done", 64'(busy), 64'(0));
      end
    end
    start = 1'b0;
    spur  = 1'b0;
  endtask

  task automatic check_pass(input string tag);
    check_eq({tag, "_reads"}, 64'(rd_cnt), 64'(2 * N));
    check_eq({tag, "_issues"}, 64'(exp_log.size()), 64'(N));
    check_eq({tag, "_writes"}, 64'(wr_data_log.size()), 64'(N));
    check_eq({tag, "_done_count"}, 64'(done_cnt), 64'(1));
    for (int i = 0; i < exp_log.size() && i < N; i++)
      check_eq($sformatf("%s_exp_data[%0d]", tag, i), 64'(exp_log[i]), 64'(want_exp[i]));
    for (int i = 0; i < wr_data_log.size() && i < N; i++) begin
      check_eq($sformatf("%s_wr_addr[%0d]", tag, i), 64'(wr_addr_log[i]), 64'(i));
      check_eq($sformatf("%s_wr_data[%0d]", tag, i), 64'(wr_data_log[i]), 64'(want_wr[i]));
    end
    check_eq({tag, "_sum"}, 64'(sum), 64'(want_sum));
    check_eq({tag, "_busy_end"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic activity;
    repeat (3) @(negedge clock);
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_rd_en", 64'(rd_en), 64'(0));
    check_eq("rst_exp_start", 64'(exp_start), 64'(0));
    check_eq("rst_wr_en", 64'(wr_en), 64'(0));
    check_eq("rst_sum", 64'(sum), 64'(0));
    reset_n = 1'b1;

    activity = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      activity |= busy | done | rd_en | wr_en | exp_start | (|rd_addr) | (|wr_addr) |
                  (|exp_data) | (|wr_data) | (|sum);
    end
    check_eq("idle_quiet", 64'(activity), 64'(0));

    load_ramp();  run_pass(3, 1'b0, 1'b0); check_pass("ramp_lat3");
    load_equal(); run_pass(3, 1'b0, 1'b0); check_pass("equal");
    load_sat();   run_pass(3, 1'b0, 1'b0); check_pass("saturate");
    load_ramp();  run_pass(1, 1'b1, 1'b0); check_pass("ramp_lat1_spurious");
    load_ramp();  run_pass(7, 1'b0, 1'b1); check_pass("ramp_lat7_restart");

    // Abort mid-EXP, then a clean pass must still be correct.
    load_ramp();
    lat = 3;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy), 64'(0));
    check_eq("abort_exp_start", 64'(exp_start), 64'(0));
    check_eq("abort_sum", 64'(sum), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    activity = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      activity |= done | wr_en | busy;
    end
    check_eq("abort_no_done", 64'(activity), 64'(0));
    run_pass(3, 1'b0, 1'b0);
    check_pass("after_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
